// File: rtl/sa_cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package sa_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFillReq,
        StFillWait,
        StRespond,
        StWtReq,
        StWtWait,
        StFlush
    } state_e;

    function automatic int unsigned calc_offset_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned calc_index_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_width,
                                               input int unsigned num_sets,
                                               input int unsigned line_words);
        return addr_width - 2 - $clog2(num_sets) - $clog2(line_words);
    endfunction

    // A direct-mapped configuration still needs a 1-bit pointer to keep widths legal.
    function automatic int unsigned calc_way_w(input int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/sa_cache_way.sv
// One cache way: tag/valid/data storage with byte-enable writes and combinational lookup.
module sa_cache_way #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INDEX_W    = 4,
    parameter int unsigned OFFSET_W   = 2,
    parameter int unsigned TAG_W      = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [INDEX_W-1:0]      index,
    input  logic [TAG_W-1:0]        tag,
    input  logic [OFFSET_W-1:0]     rd_offset,
    output logic                    hit,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    data_we,
    input  logic [OFFSET_W-1:0]     wr_offset,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    tag_we
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q [NUM_SETS][LINE_WORDS];
    logic [NUM_SETS-1:0]   valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[index] <= tag;
        end
        if (data_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    data_q[index][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign hit   = valid_q[index] && (tag_q[index] == tag);
    assign rdata = data_q[index][rd_offset];

endmodule

// File: rtl/sa_cache.sv
// N-way set-associative write-through cache with round-robin replacement and hit/miss counters.
module sa_cache
    import sa_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_req_i,
    output logic                    core_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    flush_i,
    output logic [CNT_WIDTH-1:0]    hit_cnt_o,
    output logic [CNT_WIDTH-1:0]    miss_cnt_o
);
    localparam int unsigned OFFSET_W = calc_offset_w(LINE_WORDS);
    localparam int unsigned INDEX_W  = calc_index_w(NUM_SETS);
    localparam int unsigned TAG_W    = calc_tag_w(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
    localparam int unsigned WAY_W    = calc_way_w(NUM_WAYS);
    localparam int unsigned BE_W     = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-3:0] word_addr_q;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [OFFSET_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [WAY_W-1:0]      rr_ptr_q [NUM_SETS];
    logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

    logic                  hit_inc, miss_inc, fill_we, fill_last, flush_ways, lookup_wr, any_hit;
    logic [NUM_WAYS-1:0]   way_hit;
    logic [DATA_WIDTH-1:0] way_rdata [NUM_WAYS];
    logic [DATA_WIDTH-1:0] hit_rdata;
    logic [OFFSET_W-1:0]   req_off, wr_offset;
    logic [INDEX_W-1:0]    req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [BE_W-1:0]       wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^core_addr_i[1:0];
    assign req_off = word_addr_q[OFFSET_W-1:0];
    assign req_idx = word_addr_q[OFFSET_W +: INDEX_W];
    assign req_tag = word_addr_q[ADDR_WIDTH-3 -: TAG_W];

    // Shared write port: core merge during LOOKUP, full-word store during fill.
    assign lookup_wr = (state_q == StLookup) && we_q;
    assign wr_offset = fill_we ? word_cnt_q  : req_off;
    assign wr_be     = fill_we ? {BE_W{1'b1}} : be_q;
    assign wr_data   = fill_we ? mem_rdata_i : wdata_q;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        sa_cache_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_SETS   (NUM_SETS),
            .LINE_WORDS (LINE_WORDS),
            .INDEX_W    (INDEX_W),
            .OFFSET_W   (OFFSET_W),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush_ways),
            .index     (req_idx),
            .tag       (req_tag),
            .rd_offset (req_off),
            .hit       (way_hit[w]),
            .rdata     (way_rdata[w]),
            .data_we   ((lookup_wr && way_hit[w]) || (fill_we && (victim_q == WAY_W'(w)))),
            .wr_offset (wr_offset),
            .wr_be     (wr_be),
            .wr_data   (wr_data),
            .tag_we    (fill_last && (victim_q == WAY_W'(w)))
        );
    end

    always_comb begin
        hit_rdata = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) begin
                hit_rdata = hit_rdata | way_rdata[w];
            end
        end
    end
    assign any_hit = |way_hit;

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        victim_d      = victim_q;
        flush_pend_d  = flush_pend_q | flush_i;
        core_gnt_o    = 1'b0;
        core_rvalid_o = 1'b0;
        core_rdata_o  = '0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        mem_we_o      = 1'b0;
        mem_be_o      = '0;
        mem_wdata_o   = '0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        fill_we       = 1'b0;
        fill_last     = 1'b0;
        flush_ways    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_i || flush_pend_q) begin
                    state_d = StFlush;
                end else if (core_req_i) begin
                    core_gnt_o = 1'b1;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (we_q) begin
                    hit_inc  = any_hit;
                    miss_inc = !any_hit;
                    state_d  = StWtReq;
                end else if (any_hit) begin
                    core_rvalid_o = 1'b1;
                    core_rdata_o  = hit_rdata;
                    hit_inc       = 1'b1;
                    state_d       = StIdle;
                end else begin
                    miss_inc   = 1'b1;
                    victim_d   = rr_ptr_q[req_idx];
                    word_cnt_d = '0;
                    state_d    = StFillReq;
                end
            end
            StFillReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_idx, word_cnt_q, 2'b00};
                mem_be_o   = {BE_W{1'b1}};
                if (mem_gnt_i) begin
                    state_d = StFillWait;
                end
            end
            StFillWait: begin
                if (mem_rvalid_i) begin
                    fill_we = 1'b1;
                    if (word_cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
                        fill_last = 1'b1;
                        state_d   = StRespond;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = StFillReq;
                    end
                end
            end
            StRespond: begin
                // After a fill the line now hits, so the normal hit mux supplies the word.
                core_rvalid_o = 1'b1;
                core_rdata_o  = we_q ? '0 : hit_rdata;
                state_d       = StIdle;
            end
            StWtReq: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {word_addr_q, 2'b00};
                mem_be_o    = be_q;
                mem_wdata_o = wdata_q;
                if (mem_gnt_i) begin
                    state_d = StWtWait;
                end
            end
            StWtWait: begin
                if (mem_rvalid_i) begin
                    state_d = StRespond;
                end
            end
            StFlush: begin
                flush_ways   = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            word_addr_q  <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            word_cnt_q   <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            if (core_gnt_o) begin
                word_addr_q <= core_addr_i[ADDR_WIDTH-1:2];
                we_q        <= core_we_i;
                be_q        <= core_be_i;
                wdata_q     <= core_wdata_i;
            end
            if (hit_inc && (hit_cnt_q != {CNT_WIDTH{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (miss_inc && (miss_cnt_q != {CNT_WIDTH{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            if (fill_last) begin
                rr_ptr_q[req_idx] <= (rr_ptr_q[req_idx] == WAY_W'(NUM_WAYS - 1)) ?
                                     '0 : rr_ptr_q[req_idx] + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache against a word-addressed memory preloaded with word(A) = A >> 2.
module tb_sa_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i, core_gnt_o, core_we_i, core_rvalid_o;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic [3:0]  core_be_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        flush_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    logic        mem_stall;
    logic [31:0] mem [0:4095];
    logic [31:0] rd_log [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr, last_wr_data;
    logic [3:0]  last_wr_be;

    int total = 0;
    int bad   = 0;

    sa_cache u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_addr_i   (core_addr_i),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .flush_i       (flush_i),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk = ~clk;

    assign mem_gnt_i = mem_req_o & ~mem_stall;

    // Memory responder: grant when not stalled, answer on the following cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'(i);
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
            if (mem_req_o && mem_gnt_i) begin
                mem_rvalid_i <= 1'b1;
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be_o[b]) mem[mem_addr_o[13:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                    end
                    wr_cnt       <= wr_cnt + 1;
                    last_wr_addr <= mem_addr_o;
                    last_wr_data <= mem_wdata_o;
                    last_wr_be   <= mem_be_o;
                end else begin
                    mem_rdata_i        <= mem[mem_addr_o[13:2]];
                    rd_log[rd_cnt % 256] <= mem_addr_o;
                    rd_cnt             <= rd_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core transaction; lat counts cycles from the granting edge to rvalid.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        int  n;
        bit  got;
        rd  = '0;
        lat = -1;
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = a; core_we_i = w; core_be_i = be; core_wdata_i = d;
        #1;
        n = 0;
        while (!core_gnt_o && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("gnt_wait", {31'd0, core_gnt_o}, 32'd1);
        @(posedge clk); #1;
        core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = '0; core_wdata_i = '0;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if (core_rvalid_o) begin
                got = 1'b1; rd = core_rdata_o; lat = n;
            end
        end
        chk("rvalid_wait", {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat, rb, wb;

    initial begin
        rst_n = 1'b0; core_req_i = 1'b0; core_addr_i = '0; core_we_i = 1'b0;
        core_be_i = '0; core_wdata_i = '0; flush_i = 1'b0; mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {31'd0, core_rvalid_o}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_gnt", {31'd0, core_gnt_o}, 32'd0);
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        rst_n = 1'b1;

        // Cold read miss, then hit in the same line
        rb = rd_cnt;
        access(32'h100, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("cold_rdata", rd, 32'h40);
        chk("cold_lat", 32'(lat), 32'd10);
        chk("cold_nreads", 32'(rd_cnt - rb), 32'd4);
        chk("cold_first_addr", rd_log[rb % 256], 32'h100);
        chk("cold_last_addr", rd_log[(rb + 3) % 256], 32'h10C);
        chk("cold_miss_cnt", miss_cnt_o, 32'd1);
        access(32'h104, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("hit_rdata", rd, 32'h41);
        chk("hit_lat", 32'(lat), 32'd1);
        chk("hit_cnt1", hit_cnt_o, 32'd1);

        // Write hit with partial byte enables
        rb = rd_cnt; wb = wr_cnt;
        access(32'h104, 1'b1, 4'b0011, 32'hDEAD_BEEF, rd, lat);
        chk("wr_rdata", rd, 32'h0);
        chk("wr_lat", 32'(lat), 32'd4);
        chk("wr_nwrites", 32'(wr_cnt - wb), 32'd1);
        chk("wr_nreads", 32'(rd_cnt - rb), 32'd0);
        chk("wr_be", {28'd0, last_wr_be}, 32'h3);
        chk("wr_addr", last_wr_addr, 32'h104);
        chk("wr_data", last_wr_data, 32'hDEAD_BEEF);
        chk("wr_hit_cnt", hit_cnt_o, 32'd2);
        access(32'h104, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("merge_rdata", rd, 32'h0000_BEEF);
        chk("merge_lat", 32'(lat), 32'd1);

        // Write miss: no allocate, memory updated
        rb = rd_cnt; wb = wr_cnt;
        access(32'h2000, 1'b1, 4'hF, 32'h1234_5678, rd, lat);
        chk("wmiss_nwrites", 32'(wr_cnt - wb), 32'd1);
        chk("wmiss_nreads", 32'(rd_cnt - rb), 32'd0);
        chk("wmiss_miss_cnt", miss_cnt_o, 32'd2);
        access(32'h2000, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("wmiss_reread_lat", 32'(lat), 32'd10);
        chk("wmiss_reread_rdata", rd, 32'h1234_5678);

        // Flush from idle, then fill set 0 past its two ways
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        access(32'h000, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_a_lat", 32'(lat), 32'd10);
        access(32'h400, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_b_rdata", rd, 32'h100);
        access(32'h800, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_c_rdata", rd, 32'h200);
        chk("evict_c_lat", 32'(lat), 32'd10);
        access(32'h400, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_b_hit_lat", 32'(lat), 32'd1);
        access(32'h000, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_a_miss_lat", 32'(lat), 32'd10);
        access(32'h800, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("evict_c_hit_lat", 32'(lat), 32'd1);
        chk("evict_hit_cnt", hit_cnt_o, 32'd5);
        chk("evict_miss_cnt", miss_cnt_o, 32'd7);

        // Flush arriving mid-fill is deferred until after the response
        fork
            access(32'h300, 1'b0, 4'h0, 32'h0, rd, lat);
            begin
                repeat (3) @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        chk("flushfill_rdata", rd, 32'hC0);
        chk("flushfill_lat", 32'(lat), 32'd10);
        access(32'h300, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("postflush_lat", 32'(lat), 32'd10);
        chk("postflush_miss_cnt", miss_cnt_o, 32'd9);

        // Asynchronous reset while the fill is stalled on mem_gnt_i
        mem_stall = 1'b1;
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = 32'h100; core_we_i = 1'b0;
        @(posedge clk); #1;
        core_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_mem_req", {31'd0, mem_req_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("async_hit_cnt", hit_cnt_o, 32'd0);
        chk("async_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk); mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(32'h100, 1'b0, 4'h0, 32'h0, rd, lat);
        chk("rerst_lat", 32'(lat), 32'd10);
        chk("rerst_rdata", rd, 32'h40);
        chk("rerst_miss_cnt", miss_cnt_o, 32'd1);
        chk("rerst_hit_cnt", hit_cnt_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
